// File: rtl/recip_sched_pkg.sv
// rtl/recip_sched_pkg.sv - shared state encoding and constants for the channel scheduler
package recip_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_COUNT    = 3'd2,
      S_WAIT_TDC = 3'd3,
      S_OUT      = 3'd4
   } sched_state_t;

   localparam int MIN_N            = 2;
   localparam int DEF_TIMEOUT_CLKS = 5_000_000;

endpackage

// File: rtl/recip_rr_pick.sv
// rtl/recip_rr_pick.sv - round-robin picker: first set mask bit at or after ptr, wrapping
module recip_rr_pick #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   ptr,
   output logic              found,
   output logic [CH_W-1:0]   idx
);

   logic [NUM_CH-1:0] rotated;
   logic [CH_W-1:0]   offset;
   logic [CH_W:0]     sum;

   // rotate so ptr sits at bit 0, priority-encode the lowest set bit, then undo the rotation
   always_comb begin
      rotated = NUM_CH'({mask, mask} >> ptr);
      offset  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rotated[i]) offset = CH_W'(i);
      end
      sum = {1'b0, ptr} + {1'b0, offset};
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      found = |mask;
      idx   = sum[CH_W-1:0];
   end

endmodule

// File: rtl/recip_chan_scheduler.sv
// rtl/recip_chan_scheduler.sv - shares one TDC across sensor channels for reciprocal frequency windows
module recip_chan_scheduler
   import recip_sched_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 2,
   parameter int COARSE_WIDTH = 24,
   parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       sensor_edge,
   input  logic [NUM_CH-1:0]       ch_enable,
   input  logic [15:0]             n_cycles,
   output logic                    tdc_start,
   output logic                    tdc_stop,
   output logic                    tdc_ack,
   input  logic                    tdc_valid,
   input  logic [COARSE_WIDTH-1:0] tdc_coarse,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [CH_W-1:0]         res_ch,
   output logic [15:0]             res_n,
   output logic [COARSE_WIDTH-1:0] res_coarse,
   output logic                    res_timeout,
   output logic                    busy
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CLKS - 1);

   sched_state_t    state, next_state;
   logic [CH_W-1:0] rr_ptr, cur_ch, pick_idx;
   logic            pick_found;
   logic [15:0]     n_lat, cnt, n_eff;
   logic [31:0]     timer;
   logic            cur_edge, expire;
   logic            arm_edge, arm_tmo, count_edge, count_last, count_tmo;
   logic            tdc_done, tdc_tmo, accept;

   recip_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
      .mask  (ch_enable),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign cur_edge  = sensor_edge[cur_ch];
   assign expire    = (timer >= TMO_LAST);
   assign n_eff     = (n_cycles < 16'(MIN_N)) ? 16'(MIN_N) : n_cycles;
   assign res_valid = (state == S_OUT);
   assign busy      = (state != S_IDLE);
   assign res_ch    = cur_ch;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // next-state decode; edges take priority over a coincident timer expiry
   always_comb begin
      next_state = state;
      arm_edge   = 1'b0;
      arm_tmo    = 1'b0;
      count_edge = 1'b0;
      count_last = 1'b0;
      count_tmo  = 1'b0;
      tdc_done   = 1'b0;
      tdc_tmo    = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick_found) next_state = S_ARM;
         end
         S_ARM: begin
            if (cur_edge) begin
               arm_edge   = 1'b1;
               next_state = S_COUNT;
            end else if (expire) begin
               arm_tmo    = 1'b1;
               next_state = S_OUT;
            end
         end
         S_COUNT: begin
            if (cur_edge) begin
               count_edge = 1'b1;
               if (cnt == n_lat - 16'd1) begin
                  count_last = 1'b1;
                  next_state = S_WAIT_TDC;
               end
            end else if (expire) begin
               count_tmo  = 1'b1;
               next_state = S_WAIT_TDC;
            end
         end
         S_WAIT_TDC: begin
            if (tdc_valid) begin
               tdc_done   = 1'b1;
               next_state = S_OUT;
            end else if (expire) begin
               tdc_tmo    = 1'b1;
               next_state = S_OUT;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               accept     = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // datapath: TDC pulses one cycle after their trigger, window latches, timer, round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdc_start   <= 1'b0;
         tdc_stop    <= 1'b0;
         tdc_ack     <= 1'b0;
         timer       <= '0;
         rr_ptr      <= '0;
         cur_ch      <= '0;
         n_lat       <= '0;
         cnt         <= '0;
         res_n       <= '0;
         res_coarse  <= '0;
         res_timeout <= 1'b0;
      end else begin
         tdc_start <= arm_edge;
         tdc_stop  <= count_last | count_tmo;
         tdc_ack   <= tdc_done;

         if (next_state != state || count_edge) timer <= '0;
         else if (timer != '1)                  timer <= timer + 32'd1;

         if (state == S_IDLE && pick_found) begin
            cur_ch      <= pick_idx;
            n_lat       <= n_eff;
            cnt         <= '0;
            res_n       <= '0;
            res_coarse  <= '0;
            res_timeout <= 1'b0;
         end
         if (arm_edge)   cnt <= 16'd1;
         if (count_edge) cnt <= cnt + 16'd1;
         if (arm_tmo) begin
            res_timeout <= 1'b1;
            res_n       <= '0;
            res_coarse  <= '0;
         end
         if (count_last) res_n <= n_lat;
         if (count_tmo) begin
            res_n       <= cnt;
            res_timeout <= 1'b1;
         end
         if (tdc_done) res_coarse <= tdc_coarse;
         if (tdc_tmo) begin
            res_coarse  <= '0;
            res_timeout <= 1'b1;
         end
         if (accept) begin
            res_timeout <= 1'b0;
            rr_ptr      <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_recip_chan_scheduler.sv
// tb/tb_recip_chan_scheduler.sv - self-checking bench for recip_chan_scheduler
module tb_recip_chan_scheduler;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int CW     = 24;
   localparam int TMO    = 100;
   localparam int BIG    = 32'h7fff_ffff;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    sensor_edge, ch_enable;
   logic [15:0]   n_cycles;
   logic          tdc_start, tdc_stop, tdc_ack, tdc_valid;
   logic [CW-1:0] tdc_coarse;
   logic          res_valid, res_ready, res_timeout, busy;
   logic [CH_W-1:0] res_ch;
   logic [15:0]   res_n;
   logic [CW-1:0] res_coarse;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int period[NUM_CH];
   int limit[NUM_CH];
   int emitted[NUM_CH];
   int edge_from = 0;
   int n_start = 0, n_stop = 0, n_ack = 0, start_cyc = 0;
   bit tdc_ok = 1'b1;
   int m_ptr = 0;
   int acc_cyc = 0;
   int ech, en;
   logic [3:0] msk;

   recip_chan_scheduler #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .COARSE_WIDTH(CW), .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk(clk), .rst(rst), .sensor_edge(sensor_edge), .ch_enable(ch_enable),
      .n_cycles(n_cycles), .tdc_start(tdc_start), .tdc_stop(tdc_stop), .tdc_ack(tdc_ack),
      .tdc_valid(tdc_valid), .tdc_coarse(tdc_coarse), .res_valid(res_valid),
      .res_ready(res_ready), .res_ch(res_ch), .res_n(res_n), .res_coarse(res_coarse),
      .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference round-robin: first enabled channel at or after p, wrapping
   function automatic int pick(input logic [3:0] m, input int p);
      for (int i = 0; i < NUM_CH; i++)
         if (m[(p + i) % NUM_CH]) return (p + i) % NUM_CH;
      return -1;
   endfunction

   // one clock: sample just after the edge, run the TDC model, drive next sensor edges
   task automatic cycle();
      logic [3:0] se;
      @(posedge clk);
      #1;
      cyc++;
      if (tdc_start | tdc_stop | tdc_ack)
         chk("pulse_exclusive", 32'($countones({tdc_start, tdc_stop, tdc_ack})), 1);
      if (tdc_ack) begin
         tdc_valid = 1'b0;
         n_ack++;
      end
      if (tdc_start) begin
         start_cyc = cyc;
         n_start++;
      end
      if (tdc_stop) begin
         n_stop++;
         if (tdc_ok) begin
            tdc_coarse = CW'(cyc - start_cyc);
            tdc_valid  = 1'b1;
         end
      end
      se = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (period[c] != 0 && cyc >= edge_from && (cyc % period[c]) == 0 && emitted[c] < limit[c]) begin
            se[c] = 1'b1;
            emitted[c]++;
         end
      end
      sensor_edge = se;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({tdc_start, tdc_stop, tdc_ack, res_valid, res_timeout, busy}), 0);
      chk({tag, "_ch"}, 32'(res_ch), 0);
      chk({tag, "_n"}, 32'(res_n), 0);
      chk({tag, "_coarse"}, 32'(res_coarse), 0);
   endtask

   task automatic accept(input int delay);
      for (int i = 0; i < delay; i++) cycle();
      res_ready = 1'b1;
      cycle();
      res_ready = 1'b0;
      acc_cyc = cyc;
      chk("accept_drop_valid", 32'(res_valid), 0);
      chk("accept_clear_to", 32'(res_timeout), 0);
      n_start = 0;
      n_stop  = 0;
      n_ack   = 0;
   endtask

   task automatic do_window(input string tag, input int xch, input int xn, input int xto);
      int b = 0;
      while (res_valid !== 1'b1 && b < 3000) begin
         cycle();
         b++;
      end
      chk({tag, "_valid"}, 32'(res_valid), 1);
      chk({tag, "_ch"}, 32'(res_ch), xch);
      chk({tag, "_n"}, 32'(res_n), xn);
      chk({tag, "_to"}, 32'(res_timeout), xto);
      m_ptr = (xch + 1) % NUM_CH;
   endtask

   task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
      period[0] = p0; period[1] = p1; period[2] = p2; period[3] = p3;
      for (int c = 0; c < NUM_CH; c++) begin
         limit[c]   = BIG;
         emitted[c] = 0;
      end
   endtask

   initial begin
      rst = 1'b1; ch_enable = '0; n_cycles = 16'd4; res_ready = 1'b0;
      sensor_edge = '0; tdc_valid = 1'b0; tdc_coarse = '0;
      set_periods(0, 0, 0, 0);

      // reset state, then no enabled channel keeps the scheduler idle
      repeat (3) cycle();
      chk_zero("reset");
      rst = 1'b0;
      repeat (5) cycle();
      chk("idle_no_enable_busy", 32'(busy), 0);

      // single channel, N=4, edges every 10 clk
      set_periods(10, 0, 0, 0);
      ch_enable = 4'b0001;
      do_window("basic", pick(ch_enable, m_ptr), 4, 0);
      chk("basic_coarse", 32'(res_coarse), 32'h1E);
      chk("basic_starts", n_start, 1);
      chk("basic_stops", n_stop, 1);
      chk("basic_acks", n_ack, 1);

      // consumer stalls for 50 clk; result must hold and no new window may start
      ch_enable = 4'b0011;
      set_periods(10, 7, 0, 0);
      repeat (50) cycle();
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_ch", 32'(res_ch), 0);
      chk("hold_n", 32'(res_n), 4);
      chk("hold_coarse", 32'(res_coarse), 30);
      chk("hold_starts", n_start, 1);
      accept(0);
      ech = pick(ch_enable, m_ptr);
      do_window("next", ech, 4, 0);
      chk("next_ch_is_1", ech, 1);
      chk("next_coarse", 32'(res_coarse), 3 * period[ech]);

      // reset in the middle of a counting window, then n_cycles=1 behaves as N=2
      ch_enable = 4'b0001;
      n_cycles  = 16'd8;
      set_periods(10, 0, 0, 0);
      accept(0);
      for (int b = 0; b < 300 && n_start == 0; b++) cycle();
      chk("midcount_started", n_start, 1);
      repeat (5) cycle();
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      repeat (2) cycle();
      tdc_valid = 1'b0; n_start = 0; n_stop = 0; n_ack = 0;
      n_cycles = 16'd1;
      m_ptr = 0;
      rst = 1'b0;
      do_window("rst_n2", 0, 2, 0);
      chk("rst_n2_coarse", 32'(res_coarse), 10);

      // round-robin over mask 1011 with distinct periods so each window shows its own channel
      ch_enable = 4'b1011;
      n_cycles  = 16'd3;
      set_periods(3, 5, 7, 11);
      for (int k = 0; k < 4; k++) begin
         accept(0);
         ech = pick(ch_enable, m_ptr);
         do_window("rr", ech, 3, 0);
         chk("rr_coarse", 32'(res_coarse), 2 * period[ech]);
      end

      // randomized masks, N and consumer latency against the reference model
      set_periods($urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12));
      for (int k = 0; k < 8; k++) begin
         msk       = 4'($urandom_range(1, 15));
         ch_enable = msk;
         n_cycles  = 16'($urandom_range(0, 6));
         en        = (n_cycles < 2) ? 2 : int'(n_cycles);
         accept($urandom_range(0, 5));
         ech = pick(msk, m_ptr);
         do_window("rand", ech, en, 0);
         chk("rand_coarse", 32'(res_coarse), (en - 1) * period[ech]);
      end

      // silent channel: arm timeout after IDLE(1) + ARM(TMO) cycles, no TDC traffic
      ch_enable = 4'b0100;
      set_periods(9, 9, 0, 9);
      accept(0);
      do_window("arm_tmo", 2, 0, 1);
      chk("arm_tmo_coarse", 32'(res_coarse), 0);
      chk("arm_tmo_latency", cyc - acc_cyc, 1 + TMO);
      chk("arm_tmo_starts", n_start, 0);
      chk("arm_tmo_stops", n_stop, 0);

      // channel stops after 3 edges with N=10: partial count, TDC still stopped and acked
      ch_enable = 4'b0010;
      n_cycles  = 16'd10;
      set_periods(0, 8, 0, 0);
      limit[1]  = 3;
      edge_from = cyc + 4;
      accept(0);
      do_window("partial", 1, 3, 1);
      chk("partial_coarse", 32'(res_coarse), 32'(tdc_coarse));
      chk("partial_starts", n_start, 1);
      chk("partial_stops", n_stop, 1);
      chk("partial_acks", n_ack, 1);

      // TDC never answers: result carries coarse 0 and timeout, no ack
      ch_enable = 4'b0001;
      n_cycles  = 16'd2;
      set_periods(5, 0, 0, 0);
      tdc_ok    = 1'b0;
      accept(0);
      do_window("tdc_fault", 0, 2, 1);
      chk("tdc_fault_coarse", 32'(res_coarse), 0);
      chk("tdc_fault_stops", n_stop, 1);
      chk("tdc_fault_acks", n_ack, 0);
      ch_enable = 4'b0000;
      tdc_ok    = 1'b1;
      accept(0);
      chk("final_idle", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
